// File: rtl/root_search_pkg.sv
// Shared types and sizing helpers for the root_search current-reference search engine.
package root_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEAS,
    CALC,
    DIVIDE,
    DONE,
    FAIL
  } state_t;

  localparam logic MODE_BISECT = 1'b0;
  localparam logic MODE_SECANT = 1'b1;

  // Width of a signed difference of two unsigned width-bit values.
  function automatic int diff_width(input int width);
    return width + 1;
  endfunction

  // Width of the signed secant product f1*(x1-x0), sized so it cannot overflow.
  function automatic int prod_width(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/root_search_if.sv
// Control/plant bus of root_search: search request, plant measurement handshake and status.
interface root_search_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] desired_q;
  logic [WIDTH-1:0] i_ref_setup;
  logic [WIDTH-1:0] measured_q;
  logic             ready;
  logic [WIDTH-1:0] i_ref;
  logic             busy;
  logic             converged;
  logic             failed;
  logic [7:0]       iter_count;

  modport master (
    output start, mode, desired_q, i_ref_setup, measured_q, ready,
    input  i_ref, busy, converged, failed, iter_count
  );

  modport slave (
    input  start, mode, desired_q, i_ref_setup, measured_q, ready,
    output i_ref, busy, converged, failed, iter_count
  );
endinterface

// File: rtl/root_search_seq_divider.sv
// Signed restoring divider, two quotient bits per cycle, fixed WIDTH+2 cycle latency,
// quotient truncated toward zero. Denominator must be non-zero.
module seq_divider
  import root_search_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [2*WIDTH+1:0] num,
  input  logic signed [WIDTH+1:0]   den,
  output logic signed [2*WIDTH+1:0] quo,
  output logic                      done
);
  localparam int NW    = prod_width(WIDTH);
  localparam int DW    = WIDTH + 2;
  localparam int STEPS = NW / 2;
  localparam int CW    = $clog2(STEPS + 1);

  logic          active;
  logic          neg;
  logic [CW-1:0] cnt;
  logic [NW-1:0] nq, nq_c;
  logic [DW-1:0] rem, rem_c, den_mag;
  logic [DW:0]   trial;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    rem_c = rem;
    nq_c  = nq;
    trial = '0;
    for (int k = 0; k < 2; k++) begin
      trial = {rem_c, nq_c[NW-1]};
      nq_c  = {nq_c[NW-2:0], 1'b0};
      if (trial >= {1'b0, den_mag}) begin
        trial   = trial - {1'b0, den_mag};
        nq_c[0] = 1'b1;
      end
      rem_c = trial[DW-1:0];
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      neg     <= 1'b0;
      cnt     <= '0;
      nq      <= '0;
      rem     <= '0;
      den_mag <= '0;
      quo     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        cnt     <= '0;
        rem     <= '0;
        nq      <= num[NW-1] ? NW'(-num) : NW'(num);
        den_mag <= den[DW-1] ? DW'(-den) : DW'(den);
        neg     <= num[NW-1] ^ den[DW-1];
      end else if (active) begin
        if (cnt == CW'(STEPS)) begin
          quo    <= neg ? -$signed(nq) : $signed(nq);
          done   <= 1'b1;
          active <= 1'b0;
        end else begin
          nq  <= nq_c;
          rem <= rem_c;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/root_search.sv
// Searches the reference current that makes the plant charge reading hit a target,
// by bisection (monotonic plant) or secant iteration.
module root_search
  import root_search_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int TOL      = 1,
  parameter int MAX_ITER = 32
) (
  input  logic         clk,
  input  logic         rst,
  root_search_if.slave bus
);
  localparam int FW = diff_width(WIDTH);
  localparam int PW = prod_width(WIDTH);
  localparam int QW = FW + 1;

  state_t               state;
  logic                 mode_r;
  logic                 sec_first;
  logic [WIDTH-1:0]     desired_r, meas_r, lo, hi, x0, x1, i_ref;
  logic signed [FW-1:0] f0, f1;
  logic                 busy, converged, failed;
  logic [7:0]           iter_count;

  logic                 div_start, div_done;
  logic signed [PW-1:0] div_num, div_quo;
  logic signed [QW-1:0] div_den;

  logic signed [FW-1:0] diff, dx;
  logic [FW-1:0]        abs_diff;
  logic                 is_conv, iter_limit, above, bis_stall, sec_flat;
  logic [7:0]           iter_next;
  logic [WIDTH-1:0]     new_lo, new_hi, bis_mid, sec_mid, x2;
  logic [WIDTH:0]       bis_sum, sec_sum;
  logic signed [PW-1:0] prod;
  logic signed [QW-1:0] df;
  logic signed [PW:0]   x2_raw;

  function automatic logic [WIDTH-1:0] sat_ref(input logic signed [PW:0] v);
    if (v[PW]) return '0;
    if (|v[PW-1:WIDTH]) return '1;
    return v[WIDTH-1:0];
  endfunction

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .quo   (div_quo),
    .done  (div_done)
  );

  always_comb begin
    diff       = $signed({1'b0, meas_r}) - $signed({1'b0, desired_r});
    abs_diff   = diff[FW-1] ? FW'(-diff) : FW'(diff);
    is_conv    = abs_diff <= FW'(TOL);
    iter_next  = iter_count + 8'd1;
    iter_limit = int'(iter_next) >= MAX_ITER;

    // Plant is monotonic increasing: reading above target means the root lies below i_ref.
    above     = meas_r > desired_r;
    new_lo    = above ? lo : i_ref;
    new_hi    = above ? i_ref : hi;
    bis_sum   = {1'b0, new_lo} + {1'b0, new_hi};
    bis_mid   = WIDTH'(bis_sum >> 1);
    bis_stall = (new_hi - new_lo) <= WIDTH'(1);

    dx       = $signed({1'b0, x1}) - $signed({1'b0, x0});
    prod     = $signed({{(PW-FW){diff[FW-1]}}, diff}) * $signed({{(PW-FW){dx[FW-1]}}, dx});
    df       = $signed({diff[FW-1], diff}) - $signed({f0[FW-1], f0});
    sec_flat = diff == f0;
    sec_sum  = {1'b0, x0} + {1'b0, x1};
    sec_mid  = WIDTH'(sec_sum >> 1);
    x2_raw   = $signed({1'b0, {(PW-WIDTH){1'b0}}, x1}) - $signed({div_quo[PW-1], div_quo});
    x2       = (state == DIVIDE) ? sat_ref(x2_raw) : sec_mid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode_r     <= MODE_BISECT;
      sec_first  <= 1'b0;
      desired_r  <= '0;
      meas_r     <= '0;
      lo         <= '0;
      hi         <= '0;
      x0         <= '0;
      x1         <= '0;
      f0         <= '0;
      f1         <= '0;
      i_ref      <= '0;
      busy       <= 1'b0;
      converged  <= 1'b0;
      failed     <= 1'b0;
      iter_count <= '0;
      div_start  <= 1'b0;
      div_num    <= '0;
      div_den    <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE, DONE, FAIL: begin
          if (bus.start) begin
            mode_r     <= bus.mode;
            desired_r  <= bus.desired_q;
            lo         <= '0;
            hi         <= bus.i_ref_setup;
            x0         <= '0;
            x1         <= bus.i_ref_setup;
            f0         <= '0;
            f1         <= '0;
            sec_first  <= 1'b1;
            i_ref      <= (bus.mode == MODE_SECANT) ? '0 : (bus.i_ref_setup >> 1);
            iter_count <= '0;
            converged  <= 1'b0;
            failed     <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT_MEAS;
          end
        end

        WAIT_MEAS: begin
          if (bus.ready) begin
            meas_r <= bus.measured_q;
            state  <= CALC;
          end
        end

        CALC: begin
          if (is_conv) begin
            state     <= DONE;
            busy      <= 1'b0;
            converged <= 1'b1;
          end else begin
            iter_count <= iter_next;
            if (iter_limit || (mode_r == MODE_BISECT && bis_stall) ||
                (mode_r == MODE_SECANT && !sec_first && sec_flat && x2 == x1)) begin
              state  <= FAIL;
              busy   <= 1'b0;
              failed <= 1'b1;
            end else if (mode_r == MODE_BISECT) begin
              lo    <= new_lo;
              hi    <= new_hi;
              i_ref <= bis_mid;
              state <= WAIT_MEAS;
            end else if (sec_first) begin
              f0        <= diff;
              sec_first <= 1'b0;
              i_ref     <= x1;
              state     <= WAIT_MEAS;
            end else if (sec_flat) begin
              // Flat secant: no slope information, fall back to the midpoint.
              x0    <= x1;
              f0    <= diff;
              f1    <= diff;
              x1    <= x2;
              i_ref <= x2;
              state <= WAIT_MEAS;
            end else begin
              f1        <= diff;
              div_num   <= prod;
              div_den   <= df;
              div_start <= 1'b1;
              state     <= DIVIDE;
            end
          end
        end

        DIVIDE: begin
          if (div_done) begin
            if (x2 == x1) begin
              state  <= FAIL;
              busy   <= 1'b0;
              failed <= 1'b1;
            end else begin
              x0    <= x1;
              f0    <= f1;
              x1    <= x2;
              i_ref <= x2;
              state <= WAIT_MEAS;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_ref      = i_ref;
  assign bus.busy       = busy;
  assign bus.converged  = converged;
  assign bus.failed     = failed;
  assign bus.iter_count = iter_count;

endmodule

// File: doc/root_search.md
ROOT_SEARCH -- requirements
Module: root_search

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, data width of current reference and charge measurement.
REQ-002 The block SHALL have parameter TOL, default 1, convergence tolerance |measured_q - desired_q| in LSB.
REQ-003 The block SHALL have parameter MAX_ITER, default 32, iteration limit before failure.
REQ-004 The block SHALL have ports: clk input 1 clock; rst input 1 asynchronous active-high reset.
REQ-005 The block SHALL have ports: start input 1 begin search (pulse, sampled in IDLE); mode input 1 0=bisection 1=secant (latched at start).
REQ-006 The block SHALL have ports: desired_q input WIDTH target, latched at start; i_ref_setup input WIDTH upper search bound, latched at start.
REQ-007 The block SHALL have ports: measured_q input WIDTH plant reading; ready input 1 one-cycle strobe, measured_q valid for current i_ref.
REQ-008 The block SHALL have ports: i_ref output WIDTH applied reference; busy output 1; converged output 1; failed output 1; iter_count output 8 iterations used.

Function
REQ-009 The FSM SHALL have states IDLE, WAIT_MEAS, CALC, DIVIDE, DONE, FAIL; start in IDLE moves to WAIT_MEAS, clears converged/failed/iter_count, asserts busy.
REQ-010 Bisection SHALL initialise lo=0, hi=i_ref_setup, i_ref=(lo+hi)>>1 using WIDTH+1-bit sum.
REQ-011 Secant SHALL initialise x0=0, x1=i_ref_setup; first i_ref=x0, second i_ref=x1, storing f0, f1 = measured_q - desired_q as signed WIDTH+1.
REQ-012 ready SHALL be ignored outside WAIT_MEAS; in WAIT_MEAS, ready captures measured_q and moves to CALC next cycle.
REQ-013 In CALC, |measured_q - desired_q| <= TOL SHALL move to DONE with i_ref held; convergence check precedes failure checks.
REQ-014 Otherwise iter_count SHALL increment; reaching MAX_ITER SHALL move to FAIL.
REQ-015 Bisection update (plant monotonic increasing): measured_q > desired_q sets hi=i_ref, else lo=i_ref; new midpoint applied, back to WAIT_MEAS; hi-lo <= 1 SHALL move to FAIL.
REQ-016 Secant update SHALL compute x2 = x1 - f1*(x1-x0)/(f1-f0) via DIVIDE state; quotient truncates toward zero.
REQ-017 If f1 == f0, secant SHALL skip division and use x2=(x0+x1)>>1.
REQ-018 x2 SHALL be saturated to [0, 2^WIDTH-1]; then x0<=x1, f0<=f1, x1<=x2, i_ref<=x2, back to WAIT_MEAS.
REQ-019 If saturated x2 equals x1 without convergence, secant SHALL move to FAIL.
REQ-020 DONE asserts converged, FAIL asserts failed, both deassert busy and hold until next start; start in DONE/FAIL SHALL restart directly.
REQ-021 start while busy SHALL be ignored; mode/desired_q/i_ref_setup changes while busy SHALL have no effect.
REQ-022 Product f1*(x1-x0) SHALL be 2*WIDTH+2 signed bits; no intermediate overflow permitted.

Reset
REQ-023 rst SHALL asynchronously force IDLE, i_ref=0, busy=0, converged=0, failed=0, iter_count=0, all internal registers 0, including mid-search and mid-divide.
REQ-024 First start after rst deassertion SHALL behave identically to power-up.

Structure
REQ-025 Package root_search_pkg SHALL hold the state enum, mode encoding constants, and signed-difference width function.
REQ-026 Division SHALL be a sub-module seq_divider (signed restoring, start/done handshake, WIDTH+2 cycles fixed latency), reset by same rst.

Verification
REQ-027 Bisection, plant q=i_ref/4, desired 30, setup 1023 -> converged, |q-30|<=1, iter_count<=10.
REQ-028 Secant, same plant/target -> converged within 4 iterations, i_ref in 116..127.
REQ-029 Secant, constant plant q=500, desired 30 -> f1==f0 fallback exercised, failed asserted by MAX_ITER or stall, busy low.
REQ-030 Bisection, desired 1023 unreachable (plant max 255) -> failed when hi-lo<=1, converged stays 0.
REQ-031 rst asserted during DIVIDE of secant run -> all outputs 0 same cycle; subsequent start completes normally.
REQ-032 ready pulsed in IDLE/CALC and start pulsed while busy -> no state change, iteration results unchanged.
